// File: rtl/ov7670_config_seq.sv
// ov7670_config_seq: boot-time OV7670 register sequencer.
// Walks a synchronous register table. For each entry it issues one SCCB write,
// runs a fixed wait (delay marker 16'hFFF0) or ends the pass (end marker 16'hFFFF).
// Optional macro CFG_SEQ_TIMEOUT_EN adds an `error` output and a watchdog on the
// SCCB acknowledge/complete waits.
//
// SCCB handshake: a request is presented only when sccb_ready=1 and is a
// one-cycle sccb_start pulse. The interface accepts it by dropping sccb_ready
// and completes it by raising sccb_ready again. Only one request is ever
// outstanding. sccb_address/sccb_data stay stable for the whole transaction.
module ov7670_config_seq #(
  parameter int CLK_FREQ = 25000000,
  parameter int DELAY_MS = 10,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic              sccb_ready,
  output logic              sccb_start,
  output logic [7:0]        sccb_address,
  output logic [7:0]        sccb_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] entry_count,
`ifdef CFG_SEQ_TIMEOUT_EN
  output logic              error,
`endif
  output logic [2:0]        state_dbg
);

  localparam int          DELAY_CYC  = DELAY_MS * (CLK_FREQ / 1000);
  localparam logic [31:0] DELAY_LOAD = 32'(DELAY_CYC - 1);
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};
  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK = 16'hFFF0;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, SEND, WAIT_ACK, WAIT_DONE, DELAY, ADVANCE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rom_addr_nxt, count_nxt;
  logic [7:0]        addr_nxt, data_nxt;
  logic              start_nxt, busy_nxt, done_nxt;
  logic [31:0]       cnt, cnt_nxt;

`ifdef CFG_SEQ_TIMEOUT_EN
  localparam int          WDOG_CYC  = 4 * CLK_FREQ / 1000;
  localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYC - 1);
  logic [31:0] wd, wd_nxt;
  logic        err_nxt;
`endif

  assign state_dbg = state;

  // State and datapath registers, cleared asynchronously so reset aborts at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rom_addr     <= '0;
      sccb_start   <= 1'b0;
      sccb_address <= '0;
      sccb_data    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      entry_count  <= '0;
      cnt          <= '0;
`ifdef CFG_SEQ_TIMEOUT_EN
      wd           <= '0;
      error        <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      rom_addr     <= rom_addr_nxt;
      sccb_start   <= start_nxt;
      sccb_address <= addr_nxt;
      sccb_data    <= data_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      entry_count  <= count_nxt;
      cnt          <= cnt_nxt;
`ifdef CFG_SEQ_TIMEOUT_EN
      wd           <= wd_nxt;
      error        <= err_nxt;
`endif
    end
  end

  // Next-state and next-output logic for the table walk.
  always_comb begin
    state_nxt    = state;
    rom_addr_nxt = rom_addr;
    start_nxt    = 1'b0;
    addr_nxt     = sccb_address;
    data_nxt     = sccb_data;
    busy_nxt     = busy;
    done_nxt     = done;
    count_nxt    = entry_count;
    cnt_nxt      = cnt;
`ifdef CFG_SEQ_TIMEOUT_EN
    wd_nxt       = wd;
    err_nxt      = error;
`endif
    case (state)
      IDLE: begin
        if (cfg_start) begin
          rom_addr_nxt = '0;
          count_nxt    = '0;
          done_nxt     = 1'b0;
          busy_nxt     = 1'b1;
`ifdef CFG_SEQ_TIMEOUT_EN
          err_nxt      = 1'b0;
`endif
          state_nxt    = FETCH;
        end
      end
      // Table read latency: rom_data is valid one cycle after rom_addr moves.
      FETCH: state_nxt = DECODE;
      DECODE: begin
        if (rom_data == END_MARK) begin
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (rom_data == DELAY_MARK) begin
          cnt_nxt   = DELAY_LOAD;
          state_nxt = DELAY;
        end else begin
          addr_nxt  = rom_data[15:8];
          data_nxt  = rom_data[7:0];
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (sccb_ready) begin
          start_nxt = 1'b1;
`ifdef CFG_SEQ_TIMEOUT_EN
          wd_nxt    = '0;
`endif
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!sccb_ready) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (sccb_ready) begin
          if (entry_count != LAST) count_nxt = entry_count + ADDR_W'(1);
          state_nxt = ADVANCE;
        end
      end
      DELAY: begin
        if (cnt == 32'd0) state_nxt = ADVANCE;
        else              cnt_nxt   = cnt - 32'd1;
      end
      ADVANCE: begin
        // A table with no end marker stops at the last entry instead of wrapping.
        if (rom_addr == LAST) begin
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          rom_addr_nxt = rom_addr + ADDR_W'(1);
          state_nxt    = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef CFG_SEQ_TIMEOUT_EN
    // Watchdog over the acknowledge and completion waits; expiry abandons the pass.
    if (state == WAIT_ACK || state == WAIT_DONE) begin
      if (wd == WDOG_LAST) begin
        err_nxt   = 1'b1;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        count_nxt = entry_count;
        state_nxt = IDLE;
      end else begin
        wd_nxt = wd + 32'd1;
      end
    end
`endif
  end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// tb_ov7670_config_seq: self-checking bench for ov7670_config_seq.
// Drives directed and random register tables. It checks the SCCB write stream,
// counters and flags against a table-walk reference model.
module tb_ov7670_config_seq;

  localparam int CLK_FREQ  = 1000000;
  localparam int DELAY_MS  = 1;
  localparam int ADDR_W    = 3;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int DELAY_CYC = DELAY_MS * CLK_FREQ / 1000;
  localparam int WDOG_CYC  = 4 * CLK_FREQ / 1000;
  localparam int BUDGET    = 20000;

  logic              clk;
  logic              reset_n;
  logic              cfg_start;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              sccb_ready;
  logic              sccb_start;
  logic [7:0]        sccb_address;
  logic [7:0]        sccb_data;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] entry_count;
  logic [2:0]        state_dbg;
`ifdef CFG_SEQ_TIMEOUT_EN
  logic              error;
`endif

  ov7670_config_seq #(
    .CLK_FREQ(CLK_FREQ), .DELAY_MS(DELAY_MS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb_ready(sccb_ready), .sccb_start(sccb_start),
    .sccb_address(sccb_address), .sccb_data(sccb_data),
    .busy(busy), .done(done), .entry_count(entry_count),
`ifdef CFG_SEQ_TIMEOUT_EN
    .error(error),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- table model (synchronous read) ----------------
  logic [15:0] rom [DEPTH];
  initial rom_data = 16'h0000;
  always @(posedge clk) rom_data <= rom[rom_addr];

  // ---------------- SCCB responder ----------------
  int pre_low = 0;
  bit no_ack  = 1'b0;
  initial begin
    sccb_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (pre_low > 0) begin
        sccb_ready = 1'b0;
        repeat (pre_low) @(posedge clk);
        #1 sccb_ready = 1'b1;
        pre_low = 0;
      end else if (sccb_start && !no_ack) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        if (sccb_ready) begin end
        sccb_ready = 1'b0;
        repeat ($urandom_range(4, 20)) @(posedge clk);
        #1 sccb_ready = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard capture ----------------
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  int   viol = 0;
  int   first_start_cyc = -1;
  logic ready_prev = 1'b1;
  logic start_prev = 1'b0;
  always @(negedge clk) begin
    if (sccb_start) begin
      if (start_prev) viol++;
      if (!ready_prev) viol++;
      obs_q.push_back({sccb_address, sccb_data});
      if (first_start_cyc < 0) first_start_cyc = cyc;
    end
    start_prev = sccb_start;
    ready_prev = sccb_ready;
  end

  // ---------------- reference model ----------------
  int exp_cnt, exp_last;
  task automatic model();
    exp_q.delete();
    exp_last = DEPTH - 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (rom[i] == 16'hFFFF) begin
        exp_last = i;
        break;
      end else if (rom[i] != 16'hFFF0) begin
        exp_q.push_back(rom[i]);
      end
    end
    exp_cnt = (exp_q.size() > DEPTH - 1) ? DEPTH - 1 : exp_q.size();
  endtask

  // ---------------- driver tasks ----------------
  int drive_cyc;
  task automatic kick();
    obs_q.delete();
    first_start_cyc = -1;
    viol = 0;
    @(posedge clk); #1;
    drive_cyc = cyc;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic run_pass(input string name, input bit extra, output int lat);
    int waited;
    model();
    kick();
    check({name, "_busy"}, busy, 1);
    waited = 0;
    while (!done && waited < BUDGET) begin
      @(posedge clk); #1;
      waited++;
      cfg_start = extra && busy && ($urandom_range(0, 7) == 0);
    end
    cfg_start = 1'b0;
    check({name, "_finish"}, (waited < BUDGET), 1);
    check({name, "_nwr"}, obs_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < obs_q.size()) check({name, "_wr"}, obs_q[i], exp_q[i]);
    check({name, "_cnt"}, entry_count, exp_cnt);
    check({name, "_addr"}, rom_addr, exp_last);
    check({name, "_done"}, done, 1);
    check({name, "_idle"}, busy, 0);
    check({name, "_proto"}, viol, 0);
    lat = first_start_cyc - drive_cyc;
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_addr"}, rom_addr, 0);
    check({name, "_start"}, sccb_start, 0);
    check({name, "_sa"}, sccb_address, 0);
    check({name, "_sd"}, sccb_data, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_cnt"}, entry_count, 0);
`ifdef CFG_SEQ_TIMEOUT_EN
    check({name, "_err"}, error, 0);
`endif
  endtask

  function automatic logic [15:0] rand_entry();
    logic [15:0] v;
    v = 16'($urandom_range(0, 16'hFFFF));
    if (v == 16'hFFFF || v == 16'hFFF0) v = 16'h1234;
    return v;
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = 16'hFFFF;
  endtask

  // ---------------- main sequence ----------------
  int lat, waited;
  initial begin
    reset_n   = 1'b0;
    cfg_start = 1'b0;
    clear_rom();
    repeat (3) @(posedge clk);
    #1 check_reset_vals("rst");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Two writes, then end marker; first write 4 cycles after cfg_start.
    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'h1204;
    run_pass("two", 1'b0, lat);
    check("two_lat", lat, 4);

    // Delay marker ahead of the only write.
    clear_rom();
    rom[0] = 16'hFFF0; rom[1] = 16'h1180;
    run_pass("dly", 1'b0, lat);
    check("dly_min", (lat >= DELAY_CYC), 1);

    // Interface busy at pass start, plus spurious cfg_start pulses mid-pass.
    clear_rom();
    rom[0] = 16'h1355; rom[1] = 16'h1366;
    pre_low = 50;
    repeat (2) @(posedge clk);
    run_pass("stall", 1'b1, lat);
    check("stall_wait", (lat >= 45), 1);

    // No end marker: walk stops at the last entry, count saturates.
    for (int i = 0; i < DEPTH; i++) rom[i] = rand_entry();
    run_pass("full", 1'b1, lat);

    // Reset while a write is in flight, then replay from entry 0.
    clear_rom();
    rom[0] = 16'h1401; rom[1] = 16'h1402; rom[2] = 16'h1403;
    kick();
    waited = 0;
    while ((obs_q.size() < 1 || sccb_ready) && waited < BUDGET) begin
      @(posedge clk); #1;
      waited++;
    end
    check("abort_reach", (waited < BUDGET), 1);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b0;
    #1 check_reset_vals("abort");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    waited = 0;
    while (!sccb_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    run_pass("replay", 1'b0, lat);

    // Random tables with random markers.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        case ($urandom_range(0, 11))
          0:       rom[i] = 16'hFFFF;
          1:       rom[i] = 16'hFFF0;
          default: rom[i] = rand_entry();
        endcase
      end
      run_pass($sformatf("rnd%0d", p), 1'($urandom_range(0, 1)), lat);
    end

`ifdef CFG_SEQ_TIMEOUT_EN
    // SCCB never accepts: watchdog abandons the pass with error set.
    clear_rom();
    rom[0] = 16'h1500;
    no_ack = 1'b1;
    kick();
    waited = 0;
    while (!error && waited < BUDGET) begin
      @(posedge clk); #1;
      waited++;
    end
    check("wd_err", error, 1);
    check("wd_busy", busy, 0);
    check("wd_done", done, 0);
    check("wd_min", ((cyc - drive_cyc) >= WDOG_CYC), 1);
    check("wd_max", ((cyc - drive_cyc) <= WDOG_CYC + 10), 1);
    no_ack = 1'b0;
    run_pass("wd_retry", 1'b0, lat);
    check("wd_clear", error, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
